// File: rtl/sleep_sched_pkg.sv
// Shared definitions for the sleep wake-event scheduler:
// register map, CTRL fields, timer states and helpers.
package sleep_sched_pkg;

    localparam int NUM_SRC_MAX = 31;

    localparam logic [4:0] REG_SCHED_CTRL    = 5'd0;
    localparam logic [4:0] REG_SCHED_COMPARE = 5'd1;
    localparam logic [4:0] REG_SCHED_COUNT   = 5'd2;
    localparam logic [4:0] REG_SCHED_MASK    = 5'd3;
    localparam logic [4:0] REG_SCHED_PENDING = 5'd4;
    localparam logic [4:0] REG_SCHED_STATUS  = 5'd5;

    localparam int CTRL_TIMER_EN     = 0;
    localparam int CTRL_AUTO_RELOAD  = 1;
    localparam int CTRL_PRESCALE_LSB = 8;
    localparam int CTRL_PRESCALE_MSB = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } tmr_state_e;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [4:0] lowest_set(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sleep_wakeup_scheduler_timer.sv
// Prescaled wake-up timer: prescaler, COUNT vs COMPARE and the
// IDLE/COUNT state machine. Expiry is a flop-derived strobe.
module wakeup_timer
    import sleep_sched_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        ctrl_wr,
    input  logic        en_wr,
    input  logic        auto_reload,
    input  logic [7:0]  prescale,
    input  logic [31:0] compare,
    output logic        expire,
    output logic        hw_clear,
    output logic [31:0] count
);

    tmr_state_e  state_q, state_d;
    logic [7:0]  presc_q, presc_d;
    logic [31:0] count_q, count_d;
    logic        tick;

    assign tick     = (state_q == COUNT) && (presc_q == prescale);
    assign expire   = tick && (count_q == compare);
    assign hw_clear = expire && !auto_reload;
    assign count    = count_q;

    // State, prescaler and count registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            presc_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

    // Next state: ticking, expiry handling and software start/stop.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (ctrl_wr && en_wr) begin
                    state_d = COUNT;
                    presc_d = '0;
                    count_d = '0;
                end
            end
            COUNT: begin
                if (tick) begin
                    presc_d = '0;
                    if (expire) begin
                        if (auto_reload) count_d = '0;
                        else             state_d = IDLE;
                    end else begin
                        count_d = count_q + 32'd1;
                    end
                end else begin
                    presc_d = presc_q + 8'd1;
                end
                // Software stop holds COUNT; a start racing a
                // one-shot expiry keeps the timer running afresh.
                if (ctrl_wr) begin
                    if (!en_wr) begin
                        state_d = IDLE;
                        presc_d = '0;
                        count_d = count_q;
                    end else if (hw_clear) begin
                        state_d = COUNT;
                        presc_d = '0;
                        count_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/sleep_wakeup_scheduler.sv
// Wake-event scheduler: APB registers, source edge capture,
// pending/mask logic and wake-cause record for the sleep controller.
module sleep_wakeup_scheduler
    import sleep_sched_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_SRC        = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_SRC-1:0]        event_src_i,
    input  logic                      core_sleeping_i,
    output logic                      event_o,
    output logic                      timer_irq_o
);

    localparam int NB = NUM_SRC + 1;

    logic               wr_acc;
    logic               rd_acc;
    logic [4:0]         reg_idx;
    logic               ctrl_wr;
    logic               status_rd;
    logic               timer_en_q;
    logic               auto_reload_q;
    logic [7:0]         prescale_q;
    logic [31:0]        compare_q;
    logic [NB-1:0]      mask_q;
    logic [NB-1:0]      pending_q;
    logic [NB-1:0]      set_vec;
    logic [NB-1:0]      clr_vec;
    logic [NB-1:0]      active;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise;
    logic               tmr_expire;
    logic               tmr_hw_clear;
    logic [31:0]        tmr_count;
    logic               irq_q;
    logic               event_q;
    logic               wake_capture;
    logic               wake_valid_q;
    logic [4:0]         wake_id_q;
    logic               unused_paddr;

    assign wr_acc    = PSEL & PENABLE & PWRITE;
    assign rd_acc    = PSEL & PENABLE & ~PWRITE;
    assign reg_idx   = PADDR[6:2];
    assign ctrl_wr   = wr_acc && (reg_idx == REG_SCHED_CTRL);
    assign status_rd = rd_acc && (reg_idx == REG_SCHED_STATUS);

    assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:7], PADDR[1:0]};

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    // Timer expiry takes the slot just above the external sources.
    assign rise    = event_src_i & ~src_q;
    assign set_vec = {tmr_expire, rise};
    assign clr_vec = (wr_acc && (reg_idx == REG_SCHED_PENDING)) ?
                     PWDATA[NB-1:0] : '0;

    assign active       = pending_q & mask_q;
    assign event_o      = |active;
    assign wake_capture = event_o & ~event_q;
    assign timer_irq_o  = irq_q;

    wakeup_timer u_timer (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .ctrl_wr     (ctrl_wr),
        .en_wr       (PWDATA[CTRL_TIMER_EN]),
        .auto_reload (auto_reload_q),
        .prescale    (prescale_q),
        .compare     (compare_q),
        .expire      (tmr_expire),
        .hw_clear    (tmr_hw_clear),
        .count       (tmr_count)
    );

    // Software-visible configuration; a CTRL write beats the
    // hardware clear of TIMER_EN on one-shot expiry.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            timer_en_q    <= 1'b0;
            auto_reload_q <= 1'b0;
            prescale_q    <= '0;
            compare_q     <= '0;
            mask_q        <= '0;
        end else begin
            if (ctrl_wr) begin
                timer_en_q    <= PWDATA[CTRL_TIMER_EN];
                auto_reload_q <= PWDATA[CTRL_AUTO_RELOAD];
                prescale_q    <= PWDATA[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
            end else if (tmr_hw_clear) begin
                timer_en_q <= 1'b0;
            end
            if (wr_acc && (reg_idx == REG_SCHED_COMPARE)) compare_q <= PWDATA;
            if (wr_acc && (reg_idx == REG_SCHED_MASK))    mask_q    <= PWDATA[NB-1:0];
        end
    end

    // Edge history and pending bits; a new set wins over W1C.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            src_q     <= '0;
            pending_q <= '0;
        end else begin
            src_q     <= event_src_i;
            pending_q <= (pending_q & ~clr_vec) | set_vec;
        end
    end

    // Timer pulse and wake-cause capture on the rising event edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_q        <= 1'b0;
            event_q      <= 1'b0;
            wake_valid_q <= 1'b0;
            wake_id_q    <= '0;
        end else begin
            irq_q   <= tmr_expire;
            event_q <= event_o;
            if (wake_capture) begin
                wake_id_q    <= lowest_set(32'(active));
                wake_valid_q <= core_sleeping_i;
            end else if (status_rd) begin
                wake_valid_q <= 1'b0;
            end
        end
    end

    // Read mux; data only during the access phase of a read.
    always_comb begin
        PRDATA = '0;
        if (rd_acc) begin
            case (reg_idx)
                REG_SCHED_CTRL: begin
                    PRDATA[CTRL_TIMER_EN]    = timer_en_q;
                    PRDATA[CTRL_AUTO_RELOAD] = auto_reload_q;
                    PRDATA[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB] = prescale_q;
                end
                REG_SCHED_COMPARE: PRDATA = compare_q;
                REG_SCHED_COUNT:   PRDATA = tmr_count;
                REG_SCHED_MASK:    PRDATA = 32'(mask_q);
                REG_SCHED_PENDING: PRDATA = 32'(pending_q);
                REG_SCHED_STATUS: begin
                    PRDATA[31]  = wake_valid_q;
                    PRDATA[4:0] = wake_id_q;
                end
                default: PRDATA = '0;
            endcase
        end
    end

endmodule
